// File: rtl/sequenceur_lancer_de_pkg.sv
// rtl/sequenceur_lancer_de_pkg.sv - shared state encodings, display codes and bound defaults
package sequenceur_lancer_de_pkg;

    localparam int BORNE_BAS_DEF  = 1;
    localparam int BORNE_HAUT_DEF = 100;

    typedef enum logic [2:0] {
        REPOS   = 3'd0,
        CFG_MIN = 3'd1,
        CFG_MAX = 3'd2,
        ROULE   = 3'd3,
        RALENTI = 3'd4,
        AFFICHE = 3'd5
    } etat_e;

    localparam logic [1:0] AFF_TYPE = 2'd0;
    localparam logic [1:0] AFF_MIN  = 2'd1;
    localparam logic [1:0] AFF_MAX  = 2'd2;
    localparam logic [1:0] AFF_VAL  = 2'd3;

    function automatic logic [1:0] aff_pour_etat(input etat_e e);
        case (e)
            CFG_MIN:                  return AFF_MIN;
            CFG_MAX:                  return AFF_MAX;
            ROULE, RALENTI, AFFICHE:  return AFF_VAL;
            default:                  return AFF_TYPE;
        endcase
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sequenceur_lancer_de_compteur_cyclique.sv
// rtl/sequenceur_lancer_de_compteur_cyclique.sv - free-running draw counter wrapping min..max
module compteur_cyclique #(
    parameter int VAL_RESET = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] min_i,
    input  logic [6:0] max_i,
    output logic [6:0] tirage_o
);

    logic [6:0] tirage_q;
    logic [6:0] tirage_d;

    // Out-of-window values (after a bound edit) snap back to the lower bound.
    always_comb begin
        tirage_d = tirage_q + 7'd1;
        if (tirage_q < min_i || tirage_q >= max_i) begin
            tirage_d = min_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tirage_q <= 7'(VAL_RESET);
        end else begin
            tirage_q <= tirage_d;
        end
    end

    assign tirage_o = tirage_q;

endmodule

// File: rtl/sequenceur_lancer_de.sv
// rtl/sequenceur_lancer_de.sv - dice-roll controller: bounds editing, spin/slow-down sequencing, display select
module sequenceur_lancer_de
    import sequenceur_lancer_de_pkg::*;
#(
    parameter int BORNE_BAS        = BORNE_BAS_DEF,
    parameter int BORNE_HAUT       = BORNE_HAUT_DEF,
    parameter int MIN_RESET        = 1,
    parameter int MAX_RESET        = 6,
    parameter int CYCLES_ROULEMENT = 64,
    parameter int PERIODE_BASE     = 4,
    parameter int ETAPES_RALENTI   = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_lancer,
    input  logic       btn_mode,
    input  logic       btn_plus,
    input  logic       btn_moins,
    output logic [6:0] min_de,
    output logic [6:0] max_de,
    output logic [6:0] valeur,
    output logic [1:0] etat_aff,
    output logic       occupe,
    output logic       fini
);

    localparam int CNT_MAX = max_int(CYCLES_ROULEMENT, PERIODE_BASE << ETAPES_RALENTI);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int K_W     = $clog2(ETAPES_RALENTI + 1);

    etat_e            etat_q, etat_d;
    logic [6:0]       min_q, min_d;
    logic [6:0]       max_q, max_d;
    logic [6:0]       valeur_q, valeur_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [K_W-1:0]   k_q, k_d;
    logic             fini_q, fini_d;
    logic [1:0]       etat_aff_q;
    logic             occupe_q;
    logic [6:0]       tirage;
    logic             plus_seul, moins_seul;
    logic [CNT_W-1:0] periode;

    compteur_cyclique #(
        .VAL_RESET(MIN_RESET)
    ) u_tirage (
        .clk      (clk),
        .rst      (rst),
        .min_i    (min_q),
        .max_i    (max_q),
        .tirage_o (tirage)
    );

    assign plus_seul  = btn_plus & ~btn_moins;
    assign moins_seul = btn_moins & ~btn_plus;
    assign periode    = CNT_W'(PERIODE_BASE) << k_q;

    always_comb begin
        etat_d   = etat_q;
        min_d    = min_q;
        max_d    = max_q;
        valeur_d = valeur_q;
        cnt_d    = cnt_q;
        k_d      = k_q;
        fini_d   = 1'b0;
        case (etat_q)
            REPOS: begin
                if (btn_lancer) begin
                    etat_d = ROULE;
                    cnt_d  = '0;
                end else if (btn_mode) begin
                    etat_d = CFG_MIN;
                end
            end
            CFG_MIN: begin
                if (btn_mode) begin
                    etat_d = CFG_MAX;
                end else if (plus_seul && min_q < max_q) begin
                    min_d = min_q + 7'd1;
                end else if (moins_seul && min_q > 7'(BORNE_BAS)) begin
                    min_d = min_q - 7'd1;
                end
            end
            CFG_MAX: begin
                if (btn_mode) begin
                    etat_d = REPOS;
                end else if (plus_seul && max_q < 7'(BORNE_HAUT)) begin
                    max_d = max_q + 7'd1;
                end else if (moins_seul && max_q > min_q) begin
                    max_d = max_q - 7'd1;
                end
            end
            ROULE: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q % CNT_W'(PERIODE_BASE) == CNT_W'(PERIODE_BASE - 1)) begin
                    valeur_d = tirage;
                end
                if (cnt_q == CNT_W'(CYCLES_ROULEMENT - 1)) begin
                    etat_d = RALENTI;
                    cnt_d  = '0;
                    k_d    = K_W'(1);
                end
            end
            RALENTI: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == periode - 1'b1) begin
                    valeur_d = tirage;
                    cnt_d    = '0;
                    k_d      = k_q + 1'b1;
                    if (k_q == K_W'(ETAPES_RALENTI)) begin
                        etat_d = AFFICHE;
                        fini_d = 1'b1;
                        k_d    = '0;
                    end
                end
            end
            AFFICHE: begin
                if (btn_lancer) begin
                    etat_d = ROULE;
                    cnt_d  = '0;
                end else if (btn_mode) begin
                    etat_d = REPOS;
                end
            end
            default: etat_d = REPOS;
        endcase
    end

    // Display select and busy flag are registered from the next state so they align with it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            etat_q     <= REPOS;
            min_q      <= 7'(MIN_RESET);
            max_q      <= 7'(MAX_RESET);
            valeur_q   <= 7'(MIN_RESET);
            cnt_q      <= '0;
            k_q        <= '0;
            fini_q     <= 1'b0;
            etat_aff_q <= AFF_TYPE;
            occupe_q   <= 1'b0;
        end else begin
            etat_q     <= etat_d;
            min_q      <= min_d;
            max_q      <= max_d;
            valeur_q   <= valeur_d;
            cnt_q      <= cnt_d;
            k_q        <= k_d;
            fini_q     <= fini_d;
            etat_aff_q <= aff_pour_etat(etat_d);
            occupe_q   <= (etat_d == ROULE) || (etat_d == RALENTI);
        end
    end

    assign min_de   = min_q;
    assign max_de   = max_q;
    assign valeur   = valeur_q;
    assign etat_aff = etat_aff_q;
    assign occupe   = occupe_q;
    assign fini     = fini_q;

endmodule

// File: tb/tb_sequenceur_lancer_de.sv
// tb/tb_sequenceur_lancer_de.sv - scoreboard bench for the dice-roll controller
module tb_sequenceur_lancer_de;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_lancer = 1'b0;
    logic       btn_mode = 1'b0;
    logic       btn_plus = 1'b0;
    logic       btn_moins = 1'b0;
    logic [6:0] min_de, max_de, valeur;
    logic [1:0] etat_aff;
    logic       occupe, fini;

    sequenceur_lancer_de dut (
        .clk        (clk),
        .rst        (rst),
        .btn_lancer (btn_lancer),
        .btn_mode   (btn_mode),
        .btn_plus   (btn_plus),
        .btn_moins  (btn_moins),
        .min_de     (min_de),
        .max_de     (max_de),
        .valeur     (valeur),
        .etat_aff   (etat_aff),
        .occupe     (occupe),
        .fini       (fini)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        string      nm;
        logic [6:0] mn, mx, vlo, vhi;
        logic [1:0] aff;
        logic       occ;
    } exp_t;

    typedef struct {
        int         cyc;
        logic [6:0] lo, hi;
    } fin_t;

    exp_t exp_q[$];
    fin_t fin_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string nm, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    task automatic chk_rng(input string nm, input int act, input int lo, input int hi);
        n_cmp++;
        if (act < lo || act > hi) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected in [%0d,%0d] (cycle %0d)", nm, act, lo, hi, cyc);
        end
    endtask

    // Monitor: snapshots due this cycle, plus every fini pulse against the fini queue.
    always @(negedge clk) begin
        exp_t e;
        fin_t f;
        while (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
            e = exp_q.pop_front();
            chk({e.nm, ".min_de"},   int'(min_de),   int'(e.mn));
            chk({e.nm, ".max_de"},   int'(max_de),   int'(e.mx));
            chk({e.nm, ".etat_aff"}, int'(etat_aff), int'(e.aff));
            chk({e.nm, ".occupe"},   int'(occupe),   int'(e.occ));
            chk_rng({e.nm, ".valeur"}, int'(valeur), int'(e.vlo), int'(e.vhi));
        end
        if (fini) begin
            if (fin_q.size() == 0) begin
                chk("fini_unexpected", 1, 0);
            end else begin
                f = fin_q.pop_front();
                chk("fini_cycle", cyc, f.cyc);
                chk_rng("fini_valeur", int'(valeur), int'(f.lo), int'(f.hi));
            end
        end
    end

    task automatic exp_at(input int dc, input string nm, input int mn, input int mx,
                          input int aff, input int occ, input int vlo, input int vhi);
        exp_t e;
        e.cyc = cyc + dc; e.nm = nm;
        e.mn = 7'(mn); e.mx = 7'(mx); e.vlo = 7'(vlo); e.vhi = 7'(vhi);
        e.aff = 2'(aff); e.occ = 1'(occ);
        exp_q.push_back(e);
    endtask

    task automatic fini_at(input int dc, input int lo, input int hi);
        fin_t f;
        f.cyc = cyc + dc; f.lo = 7'(lo); f.hi = 7'(hi);
        fin_q.push_back(f);
    endtask

    task automatic press(input logic l, input logic m, input logic p, input logic mo);
        btn_lancer = l; btn_mode = m; btn_plus = p; btn_moins = mo;
        @(negedge clk);
        btn_lancer = 0; btn_mode = 0; btn_plus = 0; btn_moins = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        idle(2);
        rst = 1'b0;
        exp_at(1, "reset", 1, 6, 0, 0, 1, 1);
        idle(2);

        // Default roll: fini 313 cycles after the lancer cycle
        exp_at(1,   "roll_start", 1, 6, 3, 1, 0, 127);
        exp_at(312, "roll_late",  1, 6, 3, 1, 1, 6);
        exp_at(313, "roll_done",  1, 6, 3, 0, 1, 6);
        exp_at(320, "roll_after", 1, 6, 3, 0, 1, 6);
        fini_at(313, 1, 6);
        press(1, 0, 0, 0);
        idle(330);

        // Re-roll from AFFICHE with buttons poked mid-spin
        exp_at(40,  "roll_ignore", 1, 6, 3, 1, 1, 6);
        exp_at(313, "reroll_done", 1, 6, 3, 0, 1, 6);
        fini_at(313, 1, 6);
        press(1, 0, 0, 0);
        idle(9);  press(1, 0, 0, 0);
        idle(9);  press(0, 1, 0, 0);
        idle(9);  press(0, 0, 1, 0);
        idle(300);
        exp_at(1, "back_repos", 1, 6, 0, 0, 1, 6);
        press(0, 1, 0, 0);
        idle(2);

        // Async reset in the middle of a roll
        press(1, 0, 0, 0);
        idle(20);
        rst = 1'b1;
        exp_at(1, "rst_held", 1, 6, 0, 0, 1, 1);
        idle(1);
        rst = 1'b0;
        exp_at(1, "rst_mid", 1, 6, 0, 0, 1, 1);
        idle(3);

        // Bound editing
        exp_at(1, "cfg_min", 1, 6, 1, 0, 1, 1);
        press(0, 1, 0, 0);
        press(0, 0, 1, 0);
        press(0, 0, 1, 0);
        exp_at(1, "min_plus3", 4, 6, 1, 0, 1, 1);
        press(0, 0, 1, 0);
        exp_at(1, "cfg_max", 4, 6, 2, 0, 1, 1);
        press(0, 1, 0, 0);
        repeat (9) press(0, 0, 0, 1);
        exp_at(1, "max_clamp", 4, 4, 2, 0, 1, 1);
        press(0, 0, 0, 1);
        exp_at(1, "repos_44", 4, 4, 0, 0, 1, 1);
        press(0, 1, 0, 0);
        press(0, 1, 0, 0);
        exp_at(1, "min_moins", 3, 4, 1, 0, 1, 1);
        press(0, 0, 0, 1);
        exp_at(1, "min_plus_moins", 3, 4, 1, 0, 1, 1);
        press(0, 0, 1, 1);
        press(0, 0, 1, 0);
        exp_at(1, "min_eq_max", 4, 4, 1, 0, 1, 1);
        press(0, 0, 1, 0);
        press(0, 1, 0, 0);
        repeat (95) press(0, 0, 1, 0);
        exp_at(1, "max_100", 4, 100, 2, 0, 1, 1);
        press(0, 0, 1, 0);
        exp_at(1, "max_sat", 4, 100, 2, 0, 1, 1);
        press(0, 0, 1, 0);
        press(0, 1, 0, 0);

        // lancer and mode together in REPOS: lancer wins
        exp_at(1,   "lancer_mode", 4, 100, 3, 1, 0, 127);
        exp_at(314, "wide_done",   4, 100, 3, 0, 4, 100);
        fini_at(313, 4, 100);
        press(1, 1, 0, 0);
        idle(330);

        chk("exp_queue_left", exp_q.size(), 0);
        chk("fini_queue_left", fin_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
